mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the core's single data/instruction SRAM-like memory port between the fetch stage (instruction requester) and the execute/memory stage (data requester). It runs a request/address-ok/data-ok handshake with one transaction outstanding at a time. It routes each response back to its owner and silently discards instruction responses that belong to a pipeline flushed by an exception. Data has fixed priority over instructions, with an optional anti-starvation guard.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8)
- STARVE_LIMIT, 4, consecutive data grants with an instruction waiting before instructions are forced; used only with the guard compiled in

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- excep_flush  in  1  WB exception flush; kills the in-flight instruction response
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  address accepted (1-cycle pulse)
- inst_data_ok  out  1  read data valid (1-cycle pulse)
- inst_rdata  out  DATA_W  fetched word
- data_req  in  1  load/store request; held with its fields until data_addr_ok
- data_wr  in  1  1 = store
- data_wen  in  DATA_W/8  store byte enables
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data, already lane-aligned
- data_addr_ok  out  1  address accepted (pulse)
- data_data_ok  out  1  load data valid / store complete (pulse)
- data_rdata  out  DATA_W  load word
- mem_req, mem_wr, mem_wen, mem_addr, mem_wdata  out  1/1/DATA_W/8/ADDR_W/DATA_W  memory-side request
- mem_addr_ok, mem_data_ok  in  1  memory-side handshakes
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ADDR_I, ADDR_D, WAIT_I, WAIT_D.
- IDLE:
  - data_req → ADDR_D.
  - else inst_req → ADDR_I.
  - else stay in IDLE.
- ADDR_x:
  - mem_req=1; mem_* fields are muxed combinationally from requester x.
  - For instruction requests: mem_wr=0, mem_wen=0.
  - On mem_addr_ok: pulse x_addr_ok the same cycle, go to WAIT_x.
- WAIT_x:
  - mem_req=0.
  - On mem_data_ok: pulse x_data_ok and present x_rdata=mem_rdata the same cycle, go to IDLE.
- The arbiter never abandons a request once it is in ADDR_x; the protocol requires holding until addr_ok.
- Flush handling:
  - excep_flush in ADDR_I or WAIT_I sets drop.
  - inst_data_ok is suppressed when drop=1 or when excep_flush is high in the completion cycle. The memory response is still consumed.
  - drop clears on entry to IDLE.
  - inst_addr_ok is never suppressed.
  - Data transactions are never cancelled.
- mem_data_ok in ADDR_x or IDLE is a protocol violation; it is ignored and must be flagged by an assertion.
- rdata outputs are 0 whenever the corresponding data_ok is 0.

## Timing
- Reset: state=IDLE, drop=0, starvation counter=0, all outputs 0.
- Minimum transaction, with mem_addr_ok and mem_data_ok returned in the earliest cycles:
  - cycle 0: request sampled in IDLE.
  - cycle 1: mem_req and x_addr_ok.
  - cycle 2: x_data_ok.
  - cycle 3: IDLE, next grant.
- Back-to-back throughput is therefore one transaction per 3 cycles minimum.
- Simultaneous data_req and inst_req in IDLE: data is granted (subject to the guard).
- Reset mid-transaction returns to IDLE immediately. The memory side is reset by the same resetn.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each data grant made while inst_req=1, saturating at STARVE_LIMIT.
  - When count==STARVE_LIMIT and inst_req=1, IDLE grants inst.
  - The counter clears on any inst grant.
- ARB_STARVE_GUARD_EN undefined: strict data priority; counter logic absent.

## Structure
- Shared package arb_pkg: state encoding (3-bit localparams ARB_IDLE..ARB_WAIT_D) and a requester-ID encoding (REQ_INST=0, REQ_DATA=1) for debug/trace.
- One natural sub-module, arb_grant_sel: combinational priority and starvation decision from inst_req, data_req and count. All state stays in mem_port_arbiter.

## Test plan
- Single fetch: inst_req, addr 0xBFC00000; memory returns 0x24080001 one cycle after addr_ok → inst_addr_ok at cycle 1, inst_data_ok with 0x24080001 at cycle 2, data side silent.
- Simultaneous requests: inst 0xBFC00004 and load 0x80001000 in the same cycle → data granted first (data_data_ok precedes inst_addr_ok), then inst serviced.
- Store: data_wr=1, data_wen=4'b0100, data_wdata=0x00AB0000 → mem_wen=4'b0100, mem_wdata=0x00AB0000, single data_data_ok.
- Flush: excep_flush pulsed in WAIT_I → mem_data_ok consumed, inst_data_ok stays 0, next request granted normally.
- Guard (macro on, STARVE_LIMIT=4): data_req and inst_req continuously high → 4 data grants, then 1 inst grant, repeating. With the macro off, inst is never granted.
- Async reset asserted in WAIT_D → all outputs 0 at once, IDLE on release.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM state codes and requester IDs.
package arb_pkg;

    localparam logic [2:0] ARB_IDLE   = 3'd0;
    localparam logic [2:0] ARB_ADDR_I = 3'd1;
    localparam logic [2:0] ARB_ADDR_D = 3'd2;
    localparam logic [2:0] ARB_WAIT_I = 3'd3;
    localparam logic [2:0] ARB_WAIT_D = 3'd4;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = ARB_IDLE,
        ST_ADDR_I = ARB_ADDR_I,
        ST_ADDR_D = ARB_ADDR_D,
        ST_WAIT_I = ARB_WAIT_I,
        ST_WAIT_D = ARB_WAIT_D
    } arb_state_e;

endpackage

// File: rtl/arb_grant_sel.sv
// Grant decision between fetch and load/store: data wins unless, with
// ARB_STARVE_GUARD_EN defined, the starvation count has reached its limit.
module arb_grant_sel
`ifdef ARB_STARVE_GUARD_EN
#(
    parameter  int STARVE_LIMIT = 4,
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
)
`endif
(
    input  logic             inst_req,
    input  logic             data_req,
`ifdef ARB_STARVE_GUARD_EN
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             grant_inst,
    output logic             grant_data
);

    logic force_inst;

`ifdef ARB_STARVE_GUARD_EN
    assign force_inst = inst_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
    assign force_inst = 1'b0;
`endif

    assign grant_data = data_req && !force_inst;
    assign grant_inst = inst_req && !grant_data;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store, one transaction in flight.
// Optional anti-starvation guard for fetch is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  excep_flush,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wen,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W/8-1:0]   mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata
);

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_e state_q, state_d;
    logic       drop_q, drop_d;
    logic       grant_inst, grant_data;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Counts data grants that bypassed a waiting fetch.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == ST_IDLE) begin
            if (grant_inst)
                starve_cnt_d = '0;
            else if (grant_data && inst_req && starve_cnt_q != CNT_W'(STARVE_LIMIT))
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) starve_cnt_q <= '0;
        else         starve_cnt_q <= starve_cnt_d;
    end

    arb_grant_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant_sel (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .starve_cnt (starve_cnt_q),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );
`else
    arb_grant_sel u_grant_sel (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );
`endif

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (grant_data)      state_d = ST_ADDR_D;
                else if (grant_inst) state_d = ST_ADDR_I;
            end
            ST_ADDR_I: begin
                mem_req      = 1'b1;
                mem_addr     = inst_addr;
                inst_addr_ok = mem_addr_ok;
                if (excep_flush) drop_d  = 1'b1;
                if (mem_addr_ok) state_d = ST_WAIT_I;
            end
            ST_ADDR_D: begin
                mem_req      = 1'b1;
                mem_wr       = data_wr;
                mem_wen      = data_wen;
                mem_addr     = data_addr;
                mem_wdata    = data_wdata;
                data_addr_ok = mem_addr_ok;
                if (mem_addr_ok) state_d = ST_WAIT_D;
            end
            ST_WAIT_I: begin
                if (excep_flush) drop_d = 1'b1;
                // A flushed fetch still consumes the memory response, just silently.
                if (mem_data_ok) begin
                    inst_data_ok = !drop_q && !excep_flush;
                    inst_rdata   = inst_data_ok ? mem_rdata : '0;
                    drop_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            ST_WAIT_D: begin
                if (mem_data_ok) begin
                    data_data_ok = 1'b1;
                    data_rdata   = mem_rdata;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // A response with nothing accepted is a memory-side protocol violation.
    a_no_stray_data_ok : assert property (@(posedge clk) disable iff (!resetn)
        mem_data_ok |-> (state_q == ST_WAIT_I || state_q == ST_WAIT_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LIM = 4;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          excep_flush;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr;
    logic [BW-1:0] data_wen;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          mem_req, mem_wr;
    logic [BW-1:0] mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok, mem_data_ok;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .resetn(resetn), .excep_flush(excep_flush),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                                   mem_req, mem_wr, mem_wen}), 64'd0);
        chk({name, "_maddr"}, 64'(mem_addr), 64'd0);
        chk({name, "_mwdata"}, 64'(mem_wdata), 64'd0);
        chk({name, "_irdata"}, 64'(inst_rdata), 64'd0);
        chk({name, "_drdata"}, 64'(data_rdata), 64'd0);
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic quiet_inputs();
        excep_flush = 1'b0;
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wen    = '0;
        data_addr   = '0;
        data_wdata  = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'hFFFF_0000;
    endtask

    typedef struct {
        logic          is_data;
        logic          wr;
        logic [BW-1:0] wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          flush_done;
        logic          exp_wr;
        logic [BW-1:0] exp_wen;
        logic [DW-1:0] exp_wdata;
        logic          exp_idok;
        logic          exp_ddok;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // One transaction with the earliest memory handshakes: IDLE, ADDR, WAIT, IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        quiet_inputs();
        if (v.is_data) begin
            data_req = 1'b1; data_wr = v.wr; data_wen = v.wen;
            data_addr = v.addr; data_wdata = v.wdata;
            inst_addr = 32'h1357_9BDF;
        end else begin
            inst_req = 1'b1; inst_addr = v.addr;
            data_wr = 1'b1; data_wen = '1; data_wdata = 32'hDEAD_BEEF; data_addr = 32'h0BAD_0BAD;
        end
        #1 chk({tag, "_c0_mreq"}, 64'(mem_req), 64'd0);
        @(negedge clk);
        mem_addr_ok = 1'b1;
        #1;
        chk({tag, "_c1_mreq"}, 64'(mem_req), 64'd1);
        chk({tag, "_c1_maddr"}, 64'(mem_addr), 64'(v.addr));
        chk({tag, "_c1_mwr"}, 64'(mem_wr), 64'(v.exp_wr));
        chk({tag, "_c1_mwen"}, 64'(mem_wen), 64'(v.exp_wen));
        if (v.is_data) chk({tag, "_c1_mwdata"}, 64'(mem_wdata), 64'(v.exp_wdata));
        chk({tag, "_c1_aok"}, 64'({inst_addr_ok, data_addr_ok}), v.is_data ? 64'd1 : 64'd2);
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = v.rdata;
        excep_flush = v.flush_done;
        #1;
        chk({tag, "_c2_mreq"}, 64'(mem_req), 64'd0);
        chk({tag, "_c2_dok"}, 64'({inst_data_ok, data_data_ok}), 64'({v.exp_idok, v.exp_ddok}));
        chk({tag, "_c2_irdata"}, 64'(inst_rdata), v.exp_idok ? 64'(v.exp_rdata) : 64'd0);
        chk({tag, "_c2_drdata"}, 64'(data_rdata), v.exp_ddok ? 64'(v.exp_rdata) : 64'd0);
        @(negedge clk);
        quiet_inputs();
        #1 chk({tag, "_c3_quiet"}, 64'({inst_data_ok, data_data_ok, mem_req, inst_rdata, data_rdata}), 64'd0);
    endtask

    // Random-phase requester, memory and reference-model state.
    logic          r_ireq, r_dreq, r_idrop, r_ddrop;
    logic [AW-1:0] r_iaddr, r_daddr;
    logic [DW-1:0] r_dwdata;
    logic          r_dwr;
    logic [BW-1:0] r_dwen;
    logic          p_ireq, p_dreq;
    logic          mem_pend;
    logic [AW-1:0] mem_pend_addr;
    logic          m_busy, m_busy_prev, m_in_addr, m_owner_d, m_flushed;
    logic [AW-1:0] m_addr;
    int            m_cnt;
    int            n_igrant, n_dgrant;

    initial begin
        logic exp_d;
        logic exp_iaok, exp_daok, exp_idok, exp_ddok;

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h2408_0001, 1'b0,
                    1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h2408_0001};
        vecs[1] = '{1'b1, 1'b1, 4'b0100, 32'h8000_2000, 32'h00AB_0000, 32'h0, 1'b0,
                    1'b1, 4'b0100, 32'h00AB_0000, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 4'h0, 32'hBFC0_0008, 32'h0, 32'h1111_2222, 1'b1,
                    1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 4'h0, 32'h8000_1000, 32'h5555_AAAA, 32'hCAFE_F00D, 1'b1,
                    1'b0, 4'h0, 32'h5555_AAAA, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b1, 4'b1111, 32'h8000_0FFC, 32'h0123_4567, 32'h89AB_CDEF, 1'b0,
                    1'b1, 4'b1111, 32'h0123_4567, 1'b0, 1'b1, 32'h89AB_CDEF};

        quiet_inputs();
        resetn = 1'b0;
        #23 chk_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Flush in WAIT_I before the response: drop must persist to completion.
        @(negedge clk);
        quiet_inputs(); inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
        @(negedge clk);
        mem_addr_ok = 1'b1;
        #1 chk("drop_aok", 64'(inst_addr_ok), 64'd1);
        @(negedge clk);
        inst_req = 1'b0; mem_addr_ok = 1'b0; excep_flush = 1'b1;
        #1 chk("drop_flushcyc_dok", 64'(inst_data_ok), 64'd0);
        @(negedge clk);
        excep_flush = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        #1 chk("drop_resp_dok", 64'({inst_data_ok, inst_rdata}), 64'd0);
        @(negedge clk);
        quiet_inputs();
        #1 chk("drop_idle_mreq", 64'(mem_req), 64'd0);
        run_vec(vecs[0], "after_drop");

        // Simultaneous requests: data first, then the fetch.
        @(negedge clk);
        quiet_inputs();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_addr = 32'h8000_1000;
        @(negedge clk);
        mem_addr_ok = 1'b1;
        #1 chk("sim_first_aok", 64'({inst_addr_ok, data_addr_ok}), 64'd1);
        chk("sim_first_addr", 64'(mem_addr), 64'h8000_1000);
        @(negedge clk);
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hA0A0_0001;
        #1 chk("sim_data_dok", 64'({inst_addr_ok, data_data_ok, data_rdata}), {31'd0, 1'b0, 1'b1, 32'hA0A0_0001});
        @(negedge clk);
        mem_data_ok = 1'b0;
        #1 chk("sim_idle", 64'(mem_req), 64'd0);
        @(negedge clk);
        mem_addr_ok = 1'b1;
        #1 chk("sim_inst_aok", 64'({inst_addr_ok, data_addr_ok}), 64'd2);
        chk("sim_inst_addr", 64'(mem_addr), 64'hBFC0_0004);
        @(negedge clk);
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hB0B0_0002;
        #1 chk("sim_inst_dok", 64'({inst_data_ok, inst_rdata}), {31'd0, 1'b1, 32'hB0B0_0002});
        @(negedge clk);
        quiet_inputs();

        // Both requesters held high: guard pattern (or pure data priority).
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            quiet_inputs();
            inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
            data_req = 1'b1; data_addr = 32'h8000_0100;
            @(negedge clk);
            mem_addr_ok = 1'b1;
            exp_d = GUARD ? ((k % (LIM + 1)) != LIM) : 1'b1;
            #1 chk($sformatf("guard_grant%0d", k), 64'({inst_addr_ok, data_addr_ok}), exp_d ? 64'd1 : 64'd2);
            @(negedge clk);
            mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        end
        @(negedge clk);
        quiet_inputs();

        // Async reset while a load waits for its response.
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'h8000_3000;
        @(negedge clk);
        mem_addr_ok = 1'b1;
        #1 chk("rst_aok", 64'(data_addr_ok), 64'd1);
        @(negedge clk);
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h7777_8888;
        #1 chk("rst_pre_dok", 64'(data_data_ok), 64'd1);
        #2 resetn = 1'b0;
        #1 chk_all_zero("rst_mid");
        mem_data_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        run_vec(vecs[0], "after_rst");

        // Randomized traffic against the transaction-level model.
        r_ireq = 0; r_dreq = 0; r_idrop = 0; r_ddrop = 0;
        r_iaddr = '0; r_daddr = '0; r_dwdata = '0; r_dwr = 0; r_dwen = '0;
        p_ireq = 0; p_dreq = 0; mem_pend = 0; mem_pend_addr = '0;
        m_busy = 0; m_busy_prev = 0; m_in_addr = 0; m_owner_d = 0; m_flushed = 0;
        m_addr = '0; m_cnt = 0; n_igrant = 0; n_dgrant = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (r_idrop) begin r_ireq = 0; r_idrop = 0; end
            if (r_ddrop) begin r_ddrop = 0; r_dreq = 0; end
            if (!r_ireq && $urandom_range(0, 2) == 0) begin
                r_ireq = 1; r_iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!r_dreq && $urandom_range(0, 2) == 0) begin
                r_dreq = 1; r_daddr = $urandom & 32'hFFFF_FFFC;
                r_dwr = 1'($urandom_range(0, 1)); r_dwen = 4'($urandom_range(1, 15));
                r_dwdata = $urandom;
            end
            inst_req = r_ireq; inst_addr = r_iaddr;
            data_req = r_dreq; data_addr = r_daddr; data_wr = r_dwr;
            data_wen = r_dwen; data_wdata = r_dwdata;
            excep_flush = ($urandom_range(0, 7) == 0);
            mem_addr_ok = mem_req && ($urandom_range(0, 1) == 1);
            mem_data_ok = mem_pend && ($urandom_range(0, 2) == 0);
            mem_rdata   = mem_data_ok ? memfn(mem_pend_addr) : $urandom;
            #1;
            // Grant: the cycle after an idle cycle in which someone requested.
            if (!m_busy && !m_busy_prev && (p_ireq || p_dreq)) begin
                m_busy = 1; m_in_addr = 1; m_flushed = 0;
                m_owner_d = p_dreq && !(GUARD && m_cnt == LIM && p_ireq);
                if (m_owner_d) begin
                    n_dgrant++;
                    if (p_ireq && m_cnt < LIM) m_cnt++;
                end else begin
                    n_igrant++;
                    m_cnt = 0;
                end
            end
            if (m_busy && !m_owner_d && excep_flush) m_flushed = 1;
            chk("rnd_mreq", 64'(mem_req), 64'(m_busy && m_in_addr));
            if (m_busy && m_in_addr) begin
                m_addr = m_owner_d ? r_daddr : r_iaddr;
                chk("rnd_maddr", 64'(mem_addr), 64'(m_addr));
                chk("rnd_mwr", 64'(mem_wr), m_owner_d ? 64'(r_dwr) : 64'd0);
                chk("rnd_mwen", 64'(mem_wen), m_owner_d ? 64'(r_dwen) : 64'd0);
                if (m_owner_d) chk("rnd_mwdata", 64'(mem_wdata), 64'(r_dwdata));
            end
            exp_iaok = m_busy && m_in_addr && !m_owner_d && mem_addr_ok;
            exp_daok = m_busy && m_in_addr && m_owner_d && mem_addr_ok;
            exp_idok = m_busy && !m_in_addr && !m_owner_d && mem_data_ok && !m_flushed;
            exp_ddok = m_busy && !m_in_addr && m_owner_d && mem_data_ok;
            chk("rnd_aok", 64'({inst_addr_ok, data_addr_ok}), 64'({exp_iaok, exp_daok}));
            chk("rnd_dok", 64'({inst_data_ok, data_data_ok}), 64'({exp_idok, exp_ddok}));
            chk("rnd_irdata", 64'(inst_rdata), exp_idok ? 64'(memfn(m_addr)) : 64'd0);
            chk("rnd_drdata", 64'(data_rdata), exp_ddok ? 64'(memfn(m_addr)) : 64'd0);
            m_busy_prev = m_busy;
            if (mem_req && mem_addr_ok) begin
                mem_pend = 1; mem_pend_addr = mem_addr;
            end
            if (exp_iaok) r_idrop = 1;
            if (exp_daok) r_ddrop = 1;
            if (m_busy && m_in_addr && mem_addr_ok) m_in_addr = 0;
            else if (m_busy && !m_in_addr && mem_data_ok) begin
                m_busy = 0; mem_pend = 0;
            end
            p_ireq = r_ireq; p_dreq = r_dreq;
        end
        chk("rnd_both_granted", 64'((n_igrant > 0) && (n_dgrant > 0)), 64'd1);

        @(negedge clk);
        quiet_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
